fast2slow_req_tx: RTL and testbench
===================================

FAST2SLOW_REQ_TX -- requirements
Module: fast2slow_req_tx

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the number of flops in the ack synchronizer (legal 2..4).
REQ-002 Parameter CNT_W, default 4, SHALL set the pending-event counter width (max count 2^CNT_W-1).
REQ-003 clk  input  1  SHALL be the single clock (fast/source domain); all state on rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 pulse_in  input  1  SHALL be a single-cycle event strobe to be transferred to the slow domain.
REQ-006 ack_async  input  1  SHALL be the level acknowledge returned from the slow-domain receiver, asynchronous to clk.
REQ-007 ovf_clr  input  1  SHALL clear the sticky overflow flag when high.
REQ-008 req  output  1  SHALL be the registered level request to the slow-domain receiver (4-phase).
REQ-009 busy  output  1  SHALL be high when a handshake is in progress or events are pending.
REQ-010 pend_cnt  output  CNT_W  SHALL report the number of accepted, not-yet-launched events.
REQ-011 overflow  output  1  SHALL be a sticky flag set when an event is dropped.

Function
REQ-012 ack_async SHALL pass through SYNC_STAGES flops before use; ack_s is the last stage; no other logic SHALL read ack_async.
REQ-013 FSM states SHALL be IDLE, REQ_HI, REQ_LO; req SHALL be 1 exactly when state is REQ_HI.
REQ-014 IDLE -> REQ_HI when pulse_in=1 or pend_cnt!=0 (a "launch"); otherwise stay.
REQ-015 REQ_HI -> REQ_LO when ack_s=1; otherwise stay (no timeout).
REQ-016 REQ_LO -> IDLE when ack_s=0; otherwise stay.
REQ-017 Latency: pulse_in at edge N in IDLE with pend_cnt=0 SHALL give req=1 after edge N+1 without pend_cnt changing.
REQ-018 pend_cnt next = pend_cnt + pulse_in - launch, evaluated in a single cycle; simultaneous pulse_in and launch SHALL leave pend_cnt unchanged.
REQ-019 pulse_in while pend_cnt is at max and no launch occurs that cycle SHALL drop the event, hold pend_cnt at max, and set overflow.
REQ-020 pend_cnt SHALL never wrap below 0 or above max.
REQ-021 overflow SHALL hold 1 until ovf_clr; if ovf_clr and a new drop occur in the same cycle, overflow SHALL remain 1 (set wins).
REQ-022 busy = (state!=IDLE) or (pend_cnt!=0), decoded only from registers.
REQ-023 Each accepted event SHALL produce exactly one full req rise/fall cycle; back-to-back events SHALL be serialized in order of acceptance.

Reset
REQ-024 On rst=1, state=IDLE, req=0, pend_cnt=0, overflow=0, busy=0, and all synchronizer flops=0, immediately and asynchronously.
REQ-025 Reset mid-handshake SHALL drop req at once and discard pending events; the receiver SHALL be reset coherently by the system.
REQ-026 pulse_in during rst SHALL be ignored; the first event is accepted on the first rising edge after rst deasserts.

Structure
REQ-027 Package fast2slow_pkg SHALL hold the state enumeration and the SYNC_STAGES/CNT_W defaults, shared with the matching slow-domain receiver.
REQ-028 The ack synchronizer SHALL be one sub-module, sync_ff (parameterized depth, async active-high reset, reset value 0).

Verification
REQ-029 Single pulse, ack returned 3 cycles after req rises and dropped 3 cycles after req falls -> req high 1 cycle after pulse_in, pend_cnt stays 0, busy returns to 0, overflow=0.
REQ-030 Five pulses on consecutive cycles, ack loop of ~6 cycles -> pend_cnt peaks at 4, five complete req pulses in order, final pend_cnt=0.
REQ-031 CNT_W=4, ack held low, 17 pulses -> first launches, pend_cnt saturates at 15, 17th pulse sets overflow, pend_cnt stays 15.
REQ-032 ovf_clr asserted in the same cycle as a dropping pulse -> overflow stays 1; ovf_clr alone next cycle -> overflow=0.
REQ-033 rst asserted while in REQ_HI with pend_cnt=3 -> req, pend_cnt, busy all 0 without waiting for a clk edge; a pulse after release launches normally.
REQ-034 ack_async toggled asynchronously with random phase to clk -> no state change earlier than SYNC_STAGES edges after the toggle.

Source files
------------

// File: rtl/fast2slow_pkg.sv
// Shared definitions for the fast-to-slow pulse handshake transmitter and its receiver.
package fast2slow_pkg;

    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned CNT_W_DEF       = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } f2s_state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop level synchronizer with asynchronous active-high reset to 0.
module sync_ff
    import fast2slow_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fast2slow_req_tx.sv
// Source-domain side of a 4-phase req/ack pulse transfer; queues bursts of events
// in a saturating counter and launches one full handshake per accepted event.
module fast2slow_req_tx
    import fast2slow_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             ack_async,
    input  logic             ovf_clr,
    output logic             req,
    output logic             busy,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    f2s_state_t       state;
    logic             ack_s;
    logic             launch;
    logic             drop;
    logic             active_nxt;
    logic [CNT_W-1:0] pend_nxt;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ack_async),
        .q   (ack_s)
    );

    assign launch = (state == IDLE) && (pulse_in || (pend_cnt != '0));

    // Pending count: +1 per accepted pulse, -1 per launch; a pulse at full count is dropped
    always_comb begin
        pend_nxt = pend_cnt;
        drop     = 1'b0;
        unique case ({pulse_in, launch})
            2'b10: begin
                if (pend_cnt == CNT_MAX) begin
                    drop = 1'b1;
                end else begin
                    pend_nxt = pend_cnt + CNT_W'(1);
                end
            end
            2'b01:   pend_nxt = pend_cnt - CNT_W'(1);
            default: pend_nxt = pend_cnt;
        endcase
    end

    always_comb begin
        active_nxt = 1'b0;
        unique case (state)
            IDLE:    active_nxt = launch;
            REQ_HI:  active_nxt = 1'b1;
            REQ_LO:  active_nxt = ack_s;
            default: active_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            req      <= 1'b0;
            busy     <= 1'b0;
            pend_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            pend_cnt <= pend_nxt;
            overflow <= drop | (overflow & ~ovf_clr);
            busy     <= active_nxt | (pend_nxt != '0);
            unique case (state)
                IDLE: begin
                    if (launch) begin
                        state <= REQ_HI;
                        req   <= 1'b1;
                    end
                end
                REQ_HI: begin
                    if (ack_s) begin
                        state <= REQ_LO;
                        req   <= 1'b0;
                    end
                end
                REQ_LO: begin
                    if (!ack_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fast2slow_req_tx.sv
// Self-checking bench for fast2slow_req_tx: behavioural model, event scoreboard,
// a handshake vector table and directed corner-case sequences.
module tb_fast2slow_req_tx;

    localparam int unsigned SYNC = 2;
    localparam int unsigned CW   = 4;
    localparam int PMAX    = (1 << CW) - 1;
    localparam int ACK_DLY = 3;
    localparam int NVEC    = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pulse_in = 1'b0;
    logic ack_async = 1'b0;
    logic ovf_clr = 1'b0;
    logic req;
    logic busy;
    logic overflow;
    logic [CW-1:0] pend_cnt;

    fast2slow_req_tx #(
        .SYNC_STAGES (SYNC),
        .CNT_W       (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pulse_in  (pulse_in),
        .ack_async (ack_async),
        .ovf_clr   (ovf_clr),
        .req       (req),
        .busy      (busy),
        .pend_cnt  (pend_cnt),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0=idle, 1=req high, 2=req low waiting for ack release
    logic [SYNC-1:0] m_sync;
    int m_st;
    int m_pend;
    bit m_ovf;
    int acc_id = 0;
    int sb_q[$];

    always @(posedge clk or posedge rst) begin : model
        bit m_ack;
        bit m_launch;
        bit m_drop;
        int nxt;
        if (rst) begin
            m_sync <= '0;
            m_st   <= 0;
            m_pend <= 0;
            m_ovf  <= 1'b0;
            sb_q.delete();
        end else begin
            m_ack    = m_sync[SYNC-1];
            m_sync   <= {m_sync[SYNC-2:0], ack_async};
            m_launch = (m_st == 0) && (pulse_in || m_pend != 0);
            m_drop   = pulse_in && !m_launch && (m_pend == PMAX);
            if (m_drop) nxt = m_pend;
            else        nxt = m_pend + int'(pulse_in) - int'(m_launch);
            m_pend <= nxt;
            if (m_drop)       m_ovf <= 1'b1;
            else if (ovf_clr) m_ovf <= 1'b0;
            if (pulse_in && !m_drop) begin
                sb_q.push_back(acc_id);
                acc_id++;
            end
            case (m_st)
                0: if (m_launch) m_st <= 1;
                1: if (m_ack)    m_st <= 2;
                2: if (!m_ack)   m_st <= 0;
                default: m_st <= 0;
            endcase
        end
    end

    int rises = 0;
    int peak = 0;
    int last_pop = -1;
    int ack_cnt = 0;
    bit auto_ack = 1'b0;
    logic prev_req = 1'b0;

    // One clock: compare against model, pop scoreboard on each req rise, run receiver
    task automatic step();
        int id;
        @(posedge clk);
        #1;
        chk("model_req",  int'(req),      int'(m_st == 1));
        chk("model_pend", int'(pend_cnt), m_pend);
        chk("model_ovf",  int'(overflow), int'(m_ovf));
        chk("model_busy", int'(busy),     int'(m_st != 0 || m_pend != 0));
        if (int'(pend_cnt) > peak) peak = int'(pend_cnt);
        if (req && !prev_req) begin
            rises++;
            chk("sb_pending_on_rise", int'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                id = sb_q.pop_front();
                chk("sb_order", int'(id > last_pop), 1);
                last_pop = id;
            end
        end
        prev_req = req;
        if (auto_ack) begin
            if (req != ack_async) begin
                ack_cnt++;
                if (ack_cnt >= ACK_DLY) begin
                    ack_async = req;
                    ack_cnt = 0;
                end
            end else begin
                ack_cnt = 0;
            end
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        chk({name, "_idle_timeout"}, int'(busy), 0);
    endtask

    typedef struct {
        logic p;
        logic c;
        logic a;
        logic r;
        int   pend;
        logic o;
        logic b;
    } vec_t;

    vec_t tbl [NVEC];

    task automatic setv(input int i, input logic p, input logic c, input logic a,
                        input logic r, input int pe, input logic o, input logic b);
        tbl[i].p = p; tbl[i].c = c; tbl[i].a = a;
        tbl[i].r = r; tbl[i].pend = pe; tbl[i].o = o; tbl[i].b = b;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int r0;
        int n;
        int d;

        // inputs (pulse, clr, ack) applied before the edge; outputs (req, pend, ovf, busy) after it
        setv( 0, 0,0,0, 0,0,0,0);  setv( 1, 1,0,0, 1,0,0,1);
        setv( 2, 0,1,0, 1,0,0,1);  setv( 3, 0,0,1, 1,0,0,1);
        setv( 4, 0,0,1, 1,0,0,1);  setv( 5, 0,0,1, 0,0,0,1);
        setv( 6, 0,0,0, 0,0,0,1);  setv( 7, 0,0,0, 0,0,0,1);
        setv( 8, 0,0,0, 0,0,0,0);  setv( 9, 1,0,0, 1,0,0,1);
        setv(10, 1,0,0, 1,1,0,1);  setv(11, 0,0,1, 1,1,0,1);
        setv(12, 0,0,1, 1,1,0,1);  setv(13, 0,0,1, 0,1,0,1);
        setv(14, 0,0,0, 0,1,0,1);  setv(15, 0,0,0, 0,1,0,1);
        setv(16, 0,0,0, 0,1,0,1);  setv(17, 0,0,0, 1,0,0,1);
        setv(18, 0,0,1, 1,0,0,1);  setv(19, 0,0,1, 1,0,0,1);
        setv(20, 0,0,1, 0,0,0,1);  setv(21, 0,0,0, 0,0,0,1);
        setv(22, 0,0,0, 0,0,0,1);  setv(23, 0,0,0, 0,0,0,0);

        // reset state before any clock edge
        #2;
        chk("rst_req",  int'(req),      0);
        chk("rst_pend", int'(pend_cnt), 0);
        chk("rst_ovf",  int'(overflow), 0);
        chk("rst_busy", int'(busy),     0);
        pulse_in = 1'b1;
        step();
        step();
        chk("rst_pulse_ignored", int'(pend_cnt) + int'(req), 0);
        pulse_in = 1'b0;
        rst = 1'b0;
        repeat (3) step();

        // vector table: single handshakes and a pulse arriving mid-handshake
        r0 = rises;
        for (int i = 0; i < NVEC; i++) begin
            pulse_in  = tbl[i].p;
            ovf_clr   = tbl[i].c;
            ack_async = tbl[i].a;
            step();
            chk($sformatf("tbl%0d_req", i),  int'(req),      int'(tbl[i].r));
            chk($sformatf("tbl%0d_pend", i), int'(pend_cnt), tbl[i].pend);
            chk($sformatf("tbl%0d_ovf", i),  int'(overflow), int'(tbl[i].o));
            chk($sformatf("tbl%0d_busy", i), int'(busy),     int'(tbl[i].b));
        end
        pulse_in = 1'b0; ovf_clr = 1'b0; ack_async = 1'b0;
        chk("tbl_rises", rises - r0, 3);

        // five back-to-back pulses serviced by a ~6-cycle ack loop
        auto_ack = 1'b1;
        peak = 0;
        r0 = rises;
        repeat (5) begin
            pulse_in = 1'b1;
            step();
        end
        pulse_in = 1'b0;
        wait_idle(400, "five");
        chk("five_peak",  peak, 4);
        chk("five_rises", rises - r0, 5);
        chk("five_pend",  int'(pend_cnt), 0);

        // saturation and overflow with ack held low
        auto_ack = 1'b0;
        ack_async = 1'b0;
        r0 = rises;
        for (int i = 1; i <= 17; i++) begin
            pulse_in = 1'b1;
            step();
            if (i == 1) begin
                chk("sat_first_req",  int'(req),      1);
                chk("sat_first_pend", int'(pend_cnt), 0);
            end
            if (i == 16) begin
                chk("sat16_pend", int'(pend_cnt), PMAX);
                chk("sat16_ovf",  int'(overflow), 0);
            end
            if (i == 17) begin
                chk("sat17_pend", int'(pend_cnt), PMAX);
                chk("sat17_ovf",  int'(overflow), 1);
            end
        end
        ovf_clr = 1'b1;
        step();
        chk("setwins_ovf",  int'(overflow), 1);
        chk("setwins_pend", int'(pend_cnt), PMAX);
        pulse_in = 1'b0;
        step();
        chk("clr_ovf", int'(overflow), 0);
        ovf_clr = 1'b0;
        auto_ack = 1'b1;
        wait_idle(1500, "drain");
        chk("drain_rises", rises - r0, 16);

        // asynchronous reset mid-handshake with events pending
        auto_ack = 1'b0;
        ack_async = 1'b0;
        repeat (4) begin
            pulse_in = 1'b1;
            step();
        end
        pulse_in = 1'b0;
        chk("pre_rst_req",  int'(req),      1);
        chk("pre_rst_pend", int'(pend_cnt), 3);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_req",  int'(req),      0);
        chk("async_rst_pend", int'(pend_cnt), 0);
        chk("async_rst_busy", int'(busy),     0);
        pulse_in = 1'b1;
        step();
        step();
        pulse_in = 1'b0;
        #2;
        rst = 1'b0;
        pulse_in = 1'b1;
        step();
        pulse_in = 1'b0;
        chk("post_rst_req",  int'(req),      1);
        chk("post_rst_pend", int'(pend_cnt), 0);
        auto_ack = 1'b1;
        wait_idle(200, "post_rst");

        // ack toggled at random phase: FSM reacts exactly SYNC+1 edges later
        auto_ack = 1'b0;
        ack_async = 1'b0;
        for (int it = 0; it < 4; it++) begin
            pulse_in = 1'b1;
            step();
            pulse_in = 1'b0;
            step();
            d = int'($urandom_range(1, 7));
            #d;
            ack_async = 1'b1;
            n = 0;
            do begin
                step();
                n++;
            end while (req && n < 20);
            chk($sformatf("ack_rise_lat%0d", it), n, int'(SYNC) + 1);
            d = int'($urandom_range(1, 7));
            #d;
            ack_async = 1'b0;
            n = 0;
            do begin
                step();
                n++;
            end while (busy && n < 20);
            chk($sformatf("ack_fall_lat%0d", it), n, int'(SYNC) + 1);
        end

        chk("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
